// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage.
// Fixes the default PC and instruction widths and the layout of a queued fetch entry.
// RESET_PC is the address fetched first after reset.
package fetch_pkg;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 15;

    localparam logic [ADDR_W-1:0] RESET_PC = '0;

    // One fetched instruction together with the address it came from.
    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Purpose: small synchronous FIFO holding fetched entries between fetch and decode.
// Ports:   push/pop/flush in, wr_data in, head_data/full/empty/count out.
// Timing:  a pushed entry is at the head one cycle later. Push and pop may happen
//          in the same cycle when the queue is full. Flush wins over push and pop.
module fetch_queue #(
    parameter int WIDTH = 23,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           head_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count_q;

    assign count     = count_q;
    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    // Head is read straight from registered storage; stale when empty,
    // which the consumer qualifies with !empty.
    assign head_data = mem[rd_ptr];

    // Pointers are PW bits wide, so DEPTH being a power of two makes
    // the increments wrap modulo DEPTH for free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Purpose: PC register and fetch buffer feeding decode from a combinational instruction memory.
// Ports:   clk/rst_n; im_addr/im_data to memory; jump_en/jump_target from execute;
//          out_valid/out_ready/out_instr/out_pc to decode; perf_fetched/perf_stall
//          only when FETCH_PERF_EN is defined.
// Timing:  instruction at pc appears at the queue head one cycle later; a full queue
//          with no pop holds pc; a jump flushes and costs one empty cycle.
module fetch_stage #(
    parameter int ADDR_W  = fetch_pkg::ADDR_W,
    parameter int INSTR_W = fetch_pkg::INSTR_W,
    parameter int QDEPTH  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  im_addr,
    input  logic [INSTR_W-1:0] im_data,
    input  logic               jump_en,
    input  logic [ADDR_W-1:0]  jump_target,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_stall
`endif
);

    import fetch_pkg::fetch_entry_t;
    import fetch_pkg::RESET_PC;

    // The queued entry layout comes from the package, so the widths must agree.
    if (ADDR_W != fetch_pkg::ADDR_W || INSTR_W != fetch_pkg::INSTR_W) begin : g_width_check
        $error("fetch_stage widths must match fetch_pkg");
    end

    localparam int EW = $bits(fetch_entry_t);
    localparam int CW = $clog2(QDEPTH) + 1;

    logic [ADDR_W-1:0] pc;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [CW-1:0]     q_count;
    fetch_entry_t      wr_entry;
    fetch_entry_t      head_entry;

    assign im_addr = pc;

    assign pop  = out_valid & out_ready;
    // A full queue that is being drained this cycle still accepts a new entry;
    // a jump suppresses the push because the fetched word is on the wrong path.
    assign push = (!full | pop) & !jump_en;

    assign wr_entry.pc    = pc;
    assign wr_entry.instr = im_data;

    fetch_queue #(
        .WIDTH (EW),
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .flush     (jump_en),
        .wr_data   (wr_entry),
        .head_data (head_entry),
        .full      (full),
        .empty     (empty),
        .count     (q_count)
    );

    assign out_valid = !empty;
    assign out_instr = head_entry.instr;
    assign out_pc    = head_entry.pc;

    // pc advances only when its word was actually queued; the increment wraps silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (jump_en) begin
            pc <= jump_target;
        end else if (push) begin
            pc <= pc + ADDR_W'(1);
        end
    end

    // Cross-check of the queue's status outputs.
    assert property (@(posedge clk) disable iff (!rst_n) empty == (q_count == '0));

`ifdef FETCH_PERF_EN
    // Counters are free-running statistics: jumps do not clear them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (push) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (full && !pop && !jump_en) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Purpose: directed self-checking bench for fetch_stage.
// Ports:   none; drives the DUT and models a memory with mem[i] = i.
// Timing:  inputs driven and outputs sampled 1 time unit after each rising edge.
module tb_fetch_stage;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 15;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [ADDR_W-1:0]  im_addr;
    logic [INSTR_W-1:0] im_data;
    logic               jump_en = 1'b0;
    logic [ADDR_W-1:0]  jump_target = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;
`ifdef FETCH_PERF_EN
    logic [31:0]        perf_fetched;
    logic [31:0]        perf_stall;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [INSTR_W-1:0] mem [256];

    always #5 clk = ~clk;

    assign im_data = mem[im_addr];

    fetch_stage #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W),
        .QDEPTH  (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .im_addr     (im_addr),
        .im_data     (im_data),
        .jump_en     (jump_en),
        .jump_target (jump_target),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_stall   (perf_stall)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds reset, then releases it on a falling edge; the next rising edge is cycle 1.
    task automatic do_reset(input logic rdy);
        rst_n       = 1'b0;
        jump_en     = 1'b0;
        jump_target = '0;
        out_ready   = rdy;
        #12;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        out_ready = 1'b1;
        #23;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_valid got %0b want 0", out_valid);
        end
        n_cmp++;
        if (out_pc !== 8'd0 || out_instr !== 15'd0) begin
            n_err++; $display("FAIL reset_head got pc=%0h instr=%0h want 0/0", out_pc, out_instr);
        end
        n_cmp++;
        if (im_addr !== 8'd0) begin
            n_err++; $display("FAIL reset_im_addr got %0h want 0", im_addr);
        end
`ifdef FETCH_PERF_EN
        n_cmp++;
        if (perf_fetched !== 32'd0 || perf_stall !== 32'd0) begin
            n_err++; $display("FAIL reset_perf got %0d/%0d want 0/0", perf_fetched, perf_stall);
        end
`endif
    endtask

    task automatic test_stream();
        do_reset(1'b1);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL stream_cycle0_valid got %0b want 0", out_valid);
        end
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || out_pc !== ADDR_W'(k - 1) || out_instr !== INSTR_W'(k - 1)) begin
                n_err++;
                $display("FAIL stream_cycle%0d got v=%0b pc=%0h instr=%0h want v=1 pc=%0h instr=%0h",
                         k, out_valid, out_pc, out_instr, k - 1, k - 1);
            end
        end
    endtask

    task automatic test_stall();
        do_reset(1'b0);
        tick();
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_pc !== 8'd0 || im_addr !== 8'd2) begin
            n_err++; $display("FAIL stall_fill got v=%0b head=%0h pc=%0h want v=1 head=0 pc=2",
                              out_valid, out_pc, im_addr);
        end
        for (int k = 0; k < 10; k++) begin
            tick();
            n_cmp++;
            if (im_addr !== 8'd2 || out_pc !== 8'd0 || out_instr !== 15'd0) begin
                n_err++; $display("FAIL stall_hold%0d got pc=%0h head=%0h want pc=2 head=0",
                                  k, im_addr, out_pc);
            end
        end
`ifdef FETCH_PERF_EN
        n_cmp++;
        if (perf_fetched !== 32'd2 || perf_stall !== 32'd10) begin
            n_err++; $display("FAIL stall_perf got fetched=%0d stall=%0d want 2/10", perf_fetched, perf_stall);
        end
`endif
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_pc !== ADDR_W'(k) || out_instr !== INSTR_W'(k)) begin
                n_err++; $display("FAIL stall_drain%0d got v=%0b pc=%0h want v=1 pc=%0h",
                                  k, out_valid, out_pc, k);
            end
            tick();
        end
    endtask

    task automatic test_wrap();
        do_reset(1'b1);
        tick();
        jump_en     = 1'b1;
        jump_target = 8'hFD;
        tick();
        jump_en = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || im_addr !== 8'hFD) begin
            n_err++; $display("FAIL wrap_bubble got v=%0b pc=%0h want v=0 pc=fd", out_valid, im_addr);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || out_pc !== ADDR_W'(8'hFD + k)
                || out_instr !== mem[ADDR_W'(8'hFD + k)]) begin
                n_err++; $display("FAIL wrap_seq%0d got v=%0b pc=%0h instr=%0h want pc=%0h",
                                  k, out_valid, out_pc, out_instr, ADDR_W'(8'hFD + k));
            end
        end
    endtask

    task automatic test_jump_full();
        do_reset(1'b0);
        jump_en     = 1'b1;
        jump_target = 8'd10;
        tick();
        jump_en = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_pc !== 8'd10 || im_addr !== 8'd12) begin
            n_err++; $display("FAIL jfull_setup got v=%0b head=%0h pc=%0h want v=1 head=a pc=c",
                              out_valid, out_pc, im_addr);
        end
        jump_en     = 1'b1;
        jump_target = 8'h40;
        tick();
        jump_en   = 1'b0;
        out_ready = 1'b1;
        n_cmp++;
        if (out_valid !== 1'b0 || im_addr !== 8'h40) begin
            n_err++; $display("FAIL jfull_bubble got v=%0b pc=%0h want v=0 pc=40", out_valid, im_addr);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || out_pc !== ADDR_W'(8'h40 + k) || out_instr !== INSTR_W'(8'h40 + k)) begin
                n_err++; $display("FAIL jfull_after%0d got v=%0b pc=%0h want v=1 pc=%0h",
                                  k, out_valid, out_pc, 8'h40 + k);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset(1'b1);
        tick();
        tick();
        jump_en     = 1'b1;
        jump_target = 8'h10;
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL b2b_first_bubble got v=%0b want 0", out_valid);
        end
        jump_target = 8'h20;
        tick();
        jump_en = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || im_addr !== 8'h20) begin
            n_err++; $display("FAIL b2b_second_bubble got v=%0b pc=%0h want v=0 pc=20", out_valid, im_addr);
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || out_pc !== ADDR_W'(8'h20 + k)) begin
                n_err++; $display("FAIL b2b_after%0d got v=%0b pc=%0h want v=1 pc=%0h",
                                  k, out_valid, out_pc, 8'h20 + k);
            end
        end
    endtask

    task automatic test_jump_self();
        do_reset(1'b1);
        tick();
        tick();
        tick();
        // pc is 3 here; jumping to it refetches 3 after a bubble.
        jump_en     = 1'b1;
        jump_target = 8'd3;
        tick();
        jump_en = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || im_addr !== 8'd3) begin
            n_err++; $display("FAIL jself_bubble got v=%0b pc=%0h want v=0 pc=3", out_valid, im_addr);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_pc !== 8'd3 || out_instr !== 15'd3) begin
            n_err++; $display("FAIL jself_refetch got v=%0b pc=%0h want v=1 pc=3", out_valid, out_pc);
        end
    endtask

    task automatic test_async_reset();
        do_reset(1'b1);
        for (int k = 0; k < 6; k++) begin
            tick();
        end
        n_cmp++;
        if (out_valid !== 1'b1 || out_pc !== 8'd5) begin
            n_err++; $display("FAIL areset_pre got v=%0b pc=%0h want v=1 pc=5", out_valid, out_pc);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || im_addr !== 8'd0) begin
            n_err++; $display("FAIL areset_immediate got v=%0b pc=%0h want v=0 pc=0", out_valid, im_addr);
        end
`ifdef FETCH_PERF_EN
        n_cmp++;
        if (perf_fetched !== 32'd0 || perf_stall !== 32'd0) begin
            n_err++; $display("FAIL areset_perf got %0d/%0d want 0/0", perf_fetched, perf_stall);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || out_pc !== ADDR_W'(k) || out_instr !== INSTR_W'(k)) begin
                n_err++; $display("FAIL areset_restart%0d got v=%0b pc=%0h want v=1 pc=%0h",
                                  k, out_valid, out_pc, k);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = INSTR_W'(i);
        end
        test_reset();
        test_stream();
        test_stall();
        test_wrap();
        test_jump_full();
        test_back_to_back();
        test_jump_self();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
